// File: rtl/bram_axis_pkg.sv
// bram_axis_pkg: shared widths and FSM encoding for the BRAM-to-AXIS streamer
package bram_axis_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int BRAM_WIDTH = 1152;
  localparam int ADDR_WIDTH = 12;
  localparam int WORDS = BRAM_WIDTH / DATA_WIDTH;
  localparam int CNT_W = $clog2(WORDS);
  localparam int STRB_W = DATA_WIDTH / 8;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, STREAM, DONE} state_t;
endpackage

// File: rtl/bram_axis_streamer_row_serializer.sv
// row_serializer: shifts one BRAM row out as WORDS AXIS beats, word 0 first
module row_serializer
  import bram_axis_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [BRAM_WIDTH-1:0] row,
  input  logic                  last_row,
  input  logic                  tready,
  output logic                  tvalid,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic [STRB_W-1:0]     tstrb,
  output logic                  tlast,
  output logic                  last_beat
);
  logic [BRAM_WIDTH-1:0] sr;
  logic [CNT_W-1:0]      cnt;
  assign last_beat = tvalid && cnt == CNT_W'(WORDS - 1);
  assign tdata = sr[DATA_WIDTH-1:0];
  assign tstrb = {STRB_W{tvalid}};
  assign tlast = last_beat && last_row;
  // a load wins over a handshake so a prefetched row can be swapped in on the last beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr     <= '0;
      cnt    <= '0;
      tvalid <= 1'b0;
    end else if (load) begin
      sr     <= row;
      cnt    <= '0;
      tvalid <= 1'b1;
    end else if (tvalid && tready) begin
      sr     <= sr >> DATA_WIDTH;
      cnt    <= cnt + 1'b1;
      tvalid <= !last_beat;
    end
endmodule

// File: rtl/bram_axis_streamer.sv
// bram_axis_streamer: streams BRAM rows start..bound as AXIS beats; BRAM_AXIS_PREFETCH_EN adds a prefetch row buffer
module bram_axis_streamer
  import bram_axis_pkg::*;
(
  input  logic                  m00_axis_aclk,
  input  logic                  m00_axis_aresetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] bram_start_addr,
  input  logic [ADDR_WIDTH-1:0] bram_bound_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  BRAM_CLK,
  output logic                  BRAM_EN,
  output logic                  BRAM_WEN,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  input  logic [BRAM_WIDTH-1:0] BRAM_OUT,
  output logic                  m00_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m00_axis_tdata,
  output logic [STRB_W-1:0]     m00_axis_tstrb,
  output logic                  m00_axis_tlast,
  input  logic                  m00_axis_tready
);
  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, bound;
  logic                  load, fin, last_row, last_beat, pf_issue;
  logic [BRAM_WIDTH-1:0] row;
  assign last_row = addr == bound;
  assign fin = state == STREAM && m00_axis_tvalid && m00_axis_tready && last_beat;
`ifdef BRAM_AXIS_PREFETCH_EN
  localparam bit PF = 1'b1;
  logic                  pf_sent, pf_pend;
  logic [BRAM_WIDTH-1:0] pf_buf;
  // next row is requested on the first handshake of each row that is not the bound
  assign pf_issue = state == STREAM && m00_axis_tvalid && m00_axis_tready && !pf_sent && !last_row;
  assign row = state == STREAM ? pf_buf : BRAM_OUT;
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn)
    if (!m00_axis_aresetn) begin
      pf_sent <= 1'b0;
      pf_pend <= 1'b0;
      pf_buf  <= '0;
    end else begin
      pf_sent <= load ? 1'b0 : pf_sent | pf_issue;
      pf_pend <= pf_issue;
      if (pf_pend) pf_buf <= BRAM_OUT;
    end
`else
  localparam bit PF = 1'b0;
  assign pf_issue = 1'b0;
  assign row = BRAM_OUT;
`endif
  assign load = state == WAIT || (PF && fin && !last_row);
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn)
    if (!m00_axis_aresetn) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn)
    if (!m00_axis_aresetn) begin
      addr  <= '0;
      bound <= '0;
    end else if (state == IDLE && start) begin
      addr  <= bram_start_addr;
      bound <= bram_bound_addr;
    end else if (fin && !last_row) begin
      addr  <= addr + 1'b1;
    end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = !start ? IDLE : bram_start_addr > bram_bound_addr ? DONE : FETCH;
      FETCH:   state_nxt = WAIT;
      WAIT:    state_nxt = STREAM;
      STREAM:  state_nxt = !fin ? STREAM : last_row ? DONE : PF ? STREAM : FETCH;
      default: state_nxt = IDLE;
    endcase
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign BRAM_CLK = m00_axis_aclk;
  assign BRAM_WEN = 1'b0;
  assign BRAM_EN = state == FETCH || pf_issue;
  assign BRAM_ADDR = state == FETCH ? addr : pf_issue ? addr + 1'b1 : '0;
  row_serializer u_ser (
    .clk       (m00_axis_aclk),
    .rst_n     (m00_axis_aresetn),
    .load      (load),
    .row       (row),
    .last_row  (last_row),
    .tready    (m00_axis_tready),
    .tvalid    (m00_axis_tvalid),
    .tdata     (m00_axis_tdata),
    .tstrb     (m00_axis_tstrb),
    .tlast     (m00_axis_tlast),
    .last_beat (last_beat)
  );
endmodule

// File: tb/tb_bram_axis_streamer.sv
// tb_bram_axis_streamer: randomized-stall bench with a queue-based reference of beats and BRAM reads
module tb_bram_axis_streamer;
  import bram_axis_pkg::*;
`ifdef BRAM_AXIS_PREFETCH_EN
  localparam int GAP = 0;
`else
  localparam int GAP = 2;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, tready = 1'b1;
  logic [ADDR_WIDTH-1:0] sa = '0, ba = '0;
  logic busy, done, bram_clk, bram_en, bram_wen, tvalid, tlast;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [BRAM_WIDTH-1:0] bram_out = '0;
  logic [DATA_WIDTH-1:0] tdata;
  logic [STRB_W-1:0] tstrb;
  always #5 clk = ~clk;
  bram_axis_streamer dut (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .start(start),
    .bram_start_addr(sa), .bram_bound_addr(ba), .busy(busy), .done(done),
    .BRAM_CLK(bram_clk), .BRAM_EN(bram_en), .BRAM_WEN(bram_wen), .BRAM_ADDR(bram_addr),
    .BRAM_OUT(bram_out), .m00_axis_tvalid(tvalid), .m00_axis_tdata(tdata),
    .m00_axis_tstrb(tstrb), .m00_axis_tlast(tlast), .m00_axis_tready(tready)
  );
  int total = 0, bad = 0;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  bit pat = 1'b1;
  logic [31:0] seed;
  function automatic logic [31:0] word_of(int r, int w);
    logic [31:0] x;
    x = 32'(r * 64 + w + 1);
    return pat ? (w[0] ? 32'hcccccccc : 32'haaaaaaaa) : (x * 32'h9e3779b1) ^ seed;
  endfunction
  function automatic logic [BRAM_WIDTH-1:0] row_of(int r);
    logic [BRAM_WIDTH-1:0] v;
    for (int w = 0; w < WORDS; w++) v[w*32 +: 32] = word_of(r, w);
    return v;
  endfunction
  always @(posedge clk) if (bram_en) bram_out <= row_of(int'(bram_addr));
  logic [31:0] exp_d[$];
  bit exp_l[$];
  int exp_a[$];
  int rel = 0, first_v, done_rel, last_hs, gaps, nbusy, ndone, nlast, nhs;
  bit mon_en = 1'b1, prev_stall = 1'b0, prev_l;
  logic [31:0] prev_d;
  always @(negedge clk) begin
    if (rst_n) begin
      rel++;
      if (start && !busy) rel = 0;
      if (busy) nbusy++;
      if (done) begin ndone++; done_rel = rel; end
      if (tvalid && tready) nhs++;
      if (mon_en) begin
        chk("tstrb", tstrb, {STRB_W{tvalid}});
        if (bram_en) begin
          if (exp_a.size() > 0) chk("bram_addr", bram_addr, exp_a.pop_front());
          else chk("bram_en_extra", bram_en, 0);
        end
        if (prev_stall) begin
          chk("hold_valid", tvalid, 1);
          chk("hold_data", tdata, prev_d);
          chk("hold_last", tlast, prev_l);
        end
        if (tvalid && tready) begin
          if (exp_d.size() > 0) begin
            chk("beat_data", tdata, exp_d.pop_front());
            chk("beat_last", tlast, exp_l.pop_front());
          end else chk("beat_extra", tvalid, 0);
          last_hs = rel;
          if (tlast) nlast++;
        end
        if (tvalid && first_v < 0) first_v = rel;
        if (busy && !done && !tvalid && first_v >= 0) gaps++;
      end
      prev_stall = tvalid && !tready;
      prev_d = tdata;
      prev_l = tlast;
    end else prev_stall = 1'b0;
  end
  task automatic chk_reset();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tstrb", tstrb, 0);
    chk("rst_en", bram_en, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wen", bram_wen, 0);
  endtask
  task automatic run_xfer(int s, int b, int stall, bit poke);
    int rows;
    rows = b - s + 1;
    exp_d.delete(); exp_l.delete(); exp_a.delete();
    for (int r = s; r <= b; r++) begin
      exp_a.push_back(r);
      for (int w = 0; w < WORDS; w++) begin
        exp_d.push_back(word_of(r, w));
        exp_l.push_back(r == b && w == WORDS - 1);
      end
    end
    first_v = -1; done_rel = -1; last_hs = -1;
    gaps = 0; nbusy = 0; ndone = 0; nlast = 0;
    sa = ADDR_WIDTH'(s); ba = ADDR_WIDTH'(b); start = 1'b1;
    tready = stall == 0 || $urandom_range(0, 99) >= stall;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3000 && ndone == 0; i++) begin
      tready = stall == 0 || $urandom_range(0, 99) >= stall;
      start = poke && i == 40;
      sa = start ? 12'd100 : sa;
      ba = start ? 12'd200 : ba;
      @(posedge clk); #1;
    end
    start = 1'b0; tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("ndone", ndone, 1);
    chk("beats_left", exp_d.size(), 0);
    chk("addr_left", exp_a.size(), 0);
    chk("busy_len", nbusy, done_rel);
    if (s <= b) begin
      chk("nlast", nlast, 1);
      chk("first_valid", first_v, 3);
      chk("done_lat", done_rel, last_hs + 1);
      if (stall == 0) begin
        chk("gaps", gaps, (rows - 1) * GAP);
        chk("done_cyc", done_rel, 3 + rows * WORDS + (rows - 1) * GAP);
      end
    end else begin
      chk("empty_valid", first_v, -1);
      chk("empty_done", done_rel, 1);
    end
  endtask
  initial begin
    int s;
    seed = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_xfer(5, 5, 0, 0);
    pat = 1'b0;
    run_xfer(3, 7, 0, 0);
    run_xfer(6, 7, 0, 0);
    run_xfer(6, 7, 30, 0);
    run_xfer(6, 7, 60, 0);
    run_xfer(9, 4, 0, 0);
    run_xfer(4094, 4095, 0, 0);
    run_xfer(4095, 4095, 25, 0);
    run_xfer(10, 12, 0, 1);
    repeat (4) begin
      s = $urandom_range(0, 4000);
      run_xfer(s, s + $urandom_range(0, 2), $urandom_range(0, 50), 0);
    end
    mon_en = 1'b0;
    nhs = 0;
    sa = 12'd0; ba = 12'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 500 && nhs < 2 * WORDS + 20; i++) begin
      @(posedge clk); #1;
    end
    chk("rst_reach", nhs, 2 * WORDS + 20);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    run_xfer(0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
